// File: rtl/pc_gen.sv
// Fetch-stage PC register and next-PC selection; branches/jumps resolve in D against d_pc.
// Define PC_GEN_EXC_EN to add the exc_req/eret/epc redirect inputs.
module pc_gen #(
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = WIDTH'(32'h0000_3000),
  parameter logic [WIDTH-1:0]  EXC_PC   = WIDTH'(32'h0000_4180),
  parameter int                CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [3:0]       npc_op,
  input  logic [WIDTH-1:0] d_pc,
  input  logic [25:0]      imm26,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
`ifdef PC_GEN_EXC_EN
  input  logic             exc_req,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
`endif
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc4,
  output logic [WIDTH-1:0] link,
  output logic             taken,
  output logic             adel,
  output logic [CNT_W-1:0] fetch_cnt
);

  localparam logic [3:0] OP_BEQ  = 4'd1;
  localparam logic [3:0] OP_BNE  = 4'd2;
  localparam logic [3:0] OP_BLEZ = 4'd3;
  localparam logic [3:0] OP_BGTZ = 4'd4;
  localparam logic [3:0] OP_BLTZ = 4'd5;
  localparam logic [3:0] OP_BGEZ = 4'd6;
  localparam logic [3:0] OP_J    = 4'd7;
  localparam logic [3:0] OP_JAL  = 4'd8;
  localparam logic [3:0] OP_JR   = 4'd9;

  // Bits above the 256 MB region that a J/JAL target inherits from d_pc + 4.
  localparam logic [WIDTH-1:0] REGION_MASK = ~WIDTH'({28{1'b1}});

  logic [WIDTH-1:0] d_seq;
  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] j_target;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] next_pc;
  logic             rs_neg;
  logic             rs_zero;

  assign pc4       = pc + WIDTH'(4);
  assign link      = d_pc + WIDTH'(8);
  assign d_seq     = d_pc + WIDTH'(4);
  assign br_target = d_seq + {{(WIDTH-18){imm26[15]}}, imm26[15:0], 2'b00};
  assign j_target  = (d_seq & REGION_MASK) | WIDTH'({imm26, 2'b00});
  assign rs_neg    = rs_val[WIDTH-1];
  assign rs_zero   = (rs_val == '0);

  always_comb begin
    taken  = 1'b0;
    target = br_target;
    case (npc_op)
      OP_BEQ:  taken = (rs_val == rt_val);
      OP_BNE:  taken = (rs_val != rt_val);
      OP_BLEZ: taken = rs_neg | rs_zero;
      OP_BGTZ: taken = !rs_neg && !rs_zero;
      OP_BLTZ: taken = rs_neg;
      OP_BGEZ: taken = !rs_neg;
      OP_J, OP_JAL: begin
        taken  = 1'b1;
        target = j_target;
      end
      OP_JR: begin
        taken  = 1'b1;
        target = rs_val;
      end
      default: taken = 1'b0;
    endcase
    next_pc = taken ? target : pc4;
  end

  // Misaligned targets are loaded as-is; adel lets the exception logic catch them.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      adel      <= 1'b0;
      fetch_cnt <= '0;
    end
`ifdef PC_GEN_EXC_EN
    else if (exc_req) begin
      pc        <= EXC_PC;
      adel      <= 1'b0;
      fetch_cnt <= fetch_cnt + 1'b1;
    end
    else if (eret) begin
      pc        <= epc;
      adel      <= (epc[1:0] != 2'b00);
      fetch_cnt <= fetch_cnt + 1'b1;
    end
`endif
    else if (!stall) begin
      pc        <= next_pc;
      adel      <= (next_pc[1:0] != 2'b00);
      fetch_cnt <= fetch_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Randomized scoreboard bench for pc_gen: a stimulus process pushes expectations from a
// behavioural model, a monitor pops and compares them against the DUT.
module tb_pc_gen;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
`ifdef PC_GEN_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall;
  logic [3:0]  npc_op;
  logic [31:0] d_pc, rs_val, rt_val;
  logic [25:0] imm26;
  logic [31:0] pc, pc4, link;
  logic        taken, adel;
  logic [15:0] fetch_cnt;
`ifdef PC_GEN_EXC_EN
  logic        exc_req, eret;
  logic [31:0] epc;
`endif

  pc_gen dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_op(npc_op), .d_pc(d_pc),
    .imm26(imm26), .rs_val(rs_val), .rt_val(rt_val),
`ifdef PC_GEN_EXC_EN
    .exc_req(exc_req), .eret(eret), .epc(epc),
`endif
    .pc(pc), .pc4(pc4), .link(link), .taken(taken), .adel(adel), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc4; logic [31:0] link; logic taken; } comb_t;
  typedef struct { logic [31:0] pc; logic adel; logic [15:0] cnt; } state_t;

  comb_t  comb_q[$];
  state_t state_q[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic        m_adel;
  logic [15:0] m_cnt;
  bit          m_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decide the transfer from the instruction-level rules.
  function automatic logic [32:0] ref_next(input logic [3:0] op, input logic [31:0] dpc,
                                           input logic [25:0] im, input logic [31:0] rs,
                                           input logic [31:0] rt);
    logic [31:0] seq, off;
    int signed   rsi;
    seq = dpc + 32'd4;
    off = 32'($signed(im[15:0])) * 32'd4;
    rsi = $signed(rs);
    case (op)
      4'd1: return {rs == rt, seq + off};
      4'd2: return {rs != rt, seq + off};
      4'd3: return {rsi <= 0, seq + off};
      4'd4: return {rsi > 0,  seq + off};
      4'd5: return {rsi < 0,  seq + off};
      4'd6: return {rsi >= 0, seq + off};
      4'd7, 4'd8: return {1'b1, seq[31:28], im, 2'b00};
      4'd9: return {1'b1, rs};
      default: return {1'b0, 32'd0};
    endcase
  endfunction

  // Drive one cycle of inputs, record expectations, and return at posedge+2.
  task automatic step(input logic rst, input logic st, input logic [3:0] op,
                      input logic [31:0] dpc, input logic [25:0] im,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic ex = 1'b0, input logic er = 1'b0,
                      input logic [31:0] ep = 32'd0);
    logic [32:0] r;
    logic [31:0] npc;
    comb_t c;
    state_t s;
    reset = rst; stall = st; npc_op = op; d_pc = dpc; imm26 = im; rs_val = rs; rt_val = rt;
`ifdef PC_GEN_EXC_EN
    exc_req = ex; eret = er; epc = ep;
`endif
    r = ref_next(op, dpc, im, rs, rt);
    if (m_valid) begin
      c.pc4 = m_pc + 32'd4; c.link = dpc + 32'd8; c.taken = r[32];
      comb_q.push_back(c);
    end
    npc = r[32] ? r[31:0] : m_pc + 32'd4;
    if (rst) begin
      m_pc = RESET_PC; m_adel = 1'b0; m_cnt = 16'd0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (EXC && ex) begin
        m_pc = EXC_PC; m_adel = 1'b0; m_cnt++;
      end else if (EXC && er) begin
        m_pc = ep; m_adel = (ep % 4) != 0; m_cnt++;
      end else if (!st) begin
        m_pc = npc; m_adel = (npc % 4) != 0; m_cnt++;
      end
    end
    if (m_valid) begin
      s.pc = m_pc; s.adel = m_adel; s.cnt = m_cnt;
      state_q.push_back(s);
    end
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd5;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'd1;
      5: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin : monitor
    comb_t c;
    state_t s;
    forever begin
      @(negedge clk);
      if (comb_q.size() > 0) begin
        c = comb_q.pop_front();
        chk("pc4", pc4, c.pc4);
        chk("link", link, c.link);
        chk("taken", {31'd0, taken}, {31'd0, c.taken});
      end
      @(posedge clk);
      #1;
      if (state_q.size() > 0) begin
        s = state_q.pop_front();
        chk("pc", pc, s.pc);
        chk("adel", {31'd0, adel}, {31'd0, s.adel});
        chk("fetch_cnt", {16'd0, fetch_cnt}, {16'd0, s.cnt});
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [31:0] rs, rt, dpc;
    logic [3:0]  op;
    reset = 1'b1; stall = 1'b0; npc_op = 4'd0; d_pc = '0; imm26 = '0; rs_val = '0; rt_val = '0;
`ifdef PC_GEN_EXC_EN
    exc_req = 1'b0; eret = 1'b0; epc = '0;
`endif
    @(posedge clk);
    #2;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_pc", pc, 32'h3000);
    chk("rst_cnt", {16'd0, fetch_cnt}, 32'd0);
    chk("rst_adel", {31'd0, adel}, 32'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("seq_pc1", pc, 32'h3004);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("seq_pc2", pc, 32'h3008);
    chk("seq_cnt2", {16'd0, fetch_cnt}, 32'd2);
    step(0, 0, 1, 32'h3004, 26'h000FFFF, 5, 5);
    chk("beq_taken_pc", pc, 32'h3004);
    chk("beq_taken", {31'd0, taken}, 32'd1);
    step(0, 0, 1, 32'h3004, 26'h000FFFF, 5, 6);
    chk("beq_not_taken_pc", pc, 32'h3008);
    step(0, 0, 5, 32'h3008, 26'h4, 32'h8000_0000, 0);
    chk("bltz_taken", {31'd0, taken}, 32'd1);
    step(0, 0, 6, 32'h3008, 26'h4, 0, 0);
    chk("bgez_taken", {31'd0, taken}, 32'd1);
    step(0, 0, 4, 32'h3008, 26'h4, 0, 0);
    chk("bgtz_zero", {31'd0, taken}, 32'd0);
    step(0, 0, 0, 32'h3010, 26'h4, 5, 5);
    chk("pc4_no_branch", {31'd0, taken}, 32'd0);
    step(0, 0, 8, 32'h3010, 26'h0000C40, 0, 0);
    chk("jal_pc", pc, 32'h3100);
    chk("jal_link", link, 32'h3018);
    step(0, 0, 1, 32'hFFFF_FFFC, 26'h0, 1, 1);
    chk("br_wrap", pc, 32'h0);
    step(0, 0, 9, 32'h3000, 0, 32'h3002, 0);
    chk("jr_pc", pc, 32'h3002);
    chk("jr_adel", {31'd0, adel}, 32'd1);
    for (int i = 0; i < 3; i++) step(0, 1, 7, 32'h3000, 26'h123, 0, 0);
    chk("stall_pc", pc, 32'h3002);
    chk("stall_adel", {31'd0, adel}, 32'd1);
    chk("stall_cnt", {16'd0, fetch_cnt}, {16'd0, m_cnt});
`ifdef PC_GEN_EXC_EN
    step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("exc_stall_pc", pc, 32'h4180);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3020);
    chk("eret_pc", pc, 32'h3020);
    step(0, 0, 9, 0, 0, 32'h5000, 0, 1, 1, 32'h3020);
    chk("exc_over_eret", pc, 32'h4180);
`endif
    for (int i = 0; i < 3000; i++) begin
      rs  = pick32();
      rt  = ($urandom_range(0, 2) == 0) ? rs : pick32();
      dpc = ($urandom_range(0, 7) == 0) ? $urandom : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      op  = 4'($urandom_range(0, 15));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, op, dpc, 26'($urandom),
           rs, rt, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, $urandom);
    end
    step(0, 1, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    chk("scoreboard_drain", 32'(comb_q.size() + state_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
